prio_encoder_rr: RTL and testbench

//  Parametrised, registered priority encoder with sticky request capture and valid/ready output.

---
 rtl/prio_encoder_rr.sv | 94 +++++++++
 tb/tb_prio_encoder_rr.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/prio_encoder_rr.sv
// Registered priority encoder: sticky request capture, fixed or round-robin selection,
// valid/ready output slot with pending count and overrun indication.
module prio_encoder_rr #(
  parameter int unsigned N       = 4,
  parameter int unsigned W       = $clog2(N),
  parameter bit          RR_MODE = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req_i,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [W-1:0]           out_idx,
  output logic                   out_multi,
  output logic [$clog2(N+1)-1:0] pend_cnt,
  output logic                   overrun_o
);

  localparam int unsigned CW = $clog2(N + 1);

  logic [N-1:0]  pending;
  logic [W-1:0]  ptr;

  logic [N-1:0]  cand_c;
  logic [N-1:0]  pick_oh_c;
  logic [N-1:0]  pend_nxt_c;
  logic [W-1:0]  pick_c;
  logic [W-1:0]  rr_idx_c;
  logic [CW-1:0] cand_cnt_c;
  logic          load_c;
  logic          grant_c;

  function automatic logic [CW-1:0] popcnt(input logic [N-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < int'(N); i++) c = c + CW'(v[i]);
    return c;
  endfunction

  function automatic logic [W-1:0] wrap_add(input logic [W-1:0] base, input int unsigned off);
    return W'((32'(base) + off) % N);
  endfunction

  assign cand_c  = pending | req_i;
  assign load_c  = !out_valid || out_ready;
  assign grant_c = load_c && (cand_c != '0);

  // Selection: fixed keeps the highest set index; round-robin keeps the nearest
  // set index after ptr, so the loop runs from the farthest offset inward.
  always_comb begin
    pick_c   = '0;
    rr_idx_c = '0;
    if (RR_MODE) begin
      for (int k = int'(N); k >= 1; k--) begin
        rr_idx_c = wrap_add(ptr, 32'(k));
        if (cand_c[rr_idx_c]) pick_c = rr_idx_c;
      end
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        if (cand_c[i]) pick_c = W'(i);
      end
    end
  end

  assign pick_oh_c  = N'(1) << pick_c;
  assign cand_cnt_c = popcnt(cand_c);
  // A granted bit is dropped from pending; with no grant everything is kept.
  assign pend_nxt_c = grant_c ? (cand_c & ~pick_oh_c) : cand_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= '0;
      pend_cnt  <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_multi <= 1'b0;
      overrun_o <= 1'b0;
      ptr       <= W'(N - 1);
    end else begin
      pending   <= pend_nxt_c;
      pend_cnt  <= popcnt(pend_nxt_c);
      overrun_o <= |(req_i & pending);
      if (load_c) begin
        out_valid <= grant_c;
        if (grant_c) begin
          out_idx   <= pick_c;
          out_multi <= (cand_cnt_c > CW'(1));
          if (RR_MODE) ptr <= pick_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Directed bench for prio_encoder_rr: one fixed-priority and one round-robin instance
// share stimulus; each scenario checks the instance it targets.
module tb_prio_encoder_rr;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 2;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic          ready;

  logic          f_valid, r_valid, f_multi, r_multi, f_ovr, r_ovr;
  logic [W-1:0]  f_idx, r_idx;
  logic [CW-1:0] f_cnt, r_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prio_encoder_rr #(.N(N), .RR_MODE(1'b0)) u_fix (
    .clk(clk), .rst(rst), .req_i(req), .out_ready(ready),
    .out_valid(f_valid), .out_idx(f_idx), .out_multi(f_multi),
    .pend_cnt(f_cnt), .overrun_o(f_ovr)
  );

  prio_encoder_rr #(.N(N), .RR_MODE(1'b1)) u_rr (
    .clk(clk), .rst(rst), .req_i(req), .out_ready(ready),
    .out_valid(r_valid), .out_idx(r_idx), .out_multi(r_multi),
    .pend_cnt(r_cnt), .overrun_o(r_ovr)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One rising edge, then settle on the falling edge where outputs are sampled
  // and the next inputs are driven.
  task automatic step(input logic [N-1:0] r, input logic rdy);
    req   = r;
    ready = rdy;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step('0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic expect_out(input string tag, input bit rr, input int v, input int idx,
                            input int m, input int pc);
    if (rr) begin
      check({tag, ".valid"}, 32'(r_valid), v);
      check({tag, ".cnt"},   32'(r_cnt),   pc);
      if (v != 0) begin
        check({tag, ".idx"},   32'(r_idx),   idx);
        check({tag, ".multi"}, 32'(r_multi), m);
      end
    end else begin
      check({tag, ".valid"}, 32'(f_valid), v);
      check({tag, ".cnt"},   32'(f_cnt),   pc);
      if (v != 0) begin
        check({tag, ".idx"},   32'(f_idx),   idx);
        check({tag, ".multi"}, 32'(f_multi), m);
      end
    end
  endtask

  initial begin
    int rr_seq[6] = '{0, 1, 2, 3, 0, 1};
    rst   = 1'b1;
    req   = '0;
    ready = 1'b0;
    @(negedge clk);

    // Reset state of both instances
    do_reset();
    check("rst.f_idx", 32'(f_idx), 0);
    check("rst.f_ovr", 32'(f_ovr), 0);
    check("rst.f_multi", 32'(f_multi), 0);
    expect_out("rst.f", 1'b0, 0, 0, 0, 0);
    expect_out("rst.r", 1'b1, 0, 0, 0, 0);

    // 1: fixed priority, 0110 for one cycle
    step(4'b0110, 1'b1);
    expect_out("t1.a", 1'b0, 1, 2, 1, 1);
    step(4'b0000, 1'b1);
    expect_out("t1.b", 1'b0, 1, 1, 0, 0);
    step(4'b0000, 1'b1);
    expect_out("t1.c", 1'b0, 0, 0, 0, 0);

    // 2: round-robin, all requests held
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(4'b1111, 1'b1);
      check($sformatf("t2.valid%0d", i), 32'(r_valid), 1);
      check($sformatf("t2.idx%0d", i), 32'(r_idx), rr_seq[i]);
    end

    // 3: backpressure on fixed instance
    do_reset();
    step(4'b0001, 1'b0);
    expect_out("t3.a", 1'b0, 1, 0, 0, 0);
    step(4'b0100, 1'b0);
    expect_out("t3.b", 1'b0, 1, 0, 0, 1);
    step(4'b0000, 1'b1);
    expect_out("t3.c", 1'b0, 1, 2, 0, 0);
    step(4'b0000, 1'b1);
    expect_out("t3.d", 1'b0, 0, 0, 0, 0);

    // 4: overrun on an already pending bit, single grant afterwards
    do_reset();
    step(4'b0001, 1'b0);
    step(4'b0100, 1'b0);
    check("t4.no_ovr", 32'(f_ovr), 0);
    step(4'b0100, 1'b0);
    check("t4.ovr", 32'(f_ovr), 1);
    expect_out("t4.hold", 1'b0, 1, 0, 0, 1);
    step(4'b0000, 1'b0);
    check("t4.ovr_pulse", 32'(f_ovr), 0);
    step(4'b0000, 1'b1);
    expect_out("t4.grant", 1'b0, 1, 2, 0, 0);
    step(4'b0000, 1'b1);
    expect_out("t4.once", 1'b0, 0, 0, 0, 0);

    // Re-request of the index held in out_idx: pending, no overrun, granted again
    do_reset();
    step(4'b0001, 1'b0);
    step(4'b0001, 1'b0);
    check("rereq.ovr", 32'(f_ovr), 0);
    expect_out("rereq.hold", 1'b0, 1, 0, 0, 1);
    step(4'b0000, 1'b1);
    expect_out("rereq.grant", 1'b0, 1, 0, 0, 0);

    // 5: reset mid-operation on round-robin with ptr=2 and three pending
    do_reset();
    step(4'b0100, 1'b1);
    expect_out("t5.a", 1'b1, 1, 2, 0, 0);
    step(4'b1011, 1'b0);
    expect_out("t5.b", 1'b1, 1, 2, 0, 3);
    rst = 1'b1;
    step(4'b0000, 1'b0);
    rst = 1'b0;
    check("t5.idx", 32'(r_idx), 0);
    check("t5.multi", 32'(r_multi), 0);
    check("t5.ovr", 32'(r_ovr), 0);
    expect_out("t5.rst", 1'b1, 0, 0, 0, 0);
    step(4'b1111, 1'b1);
    expect_out("t5.first", 1'b1, 1, 0, 1, 3);

    // 6: idle with toggling out_ready
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(4'b0000, 1'(i % 2));
      check($sformatf("t6.f_valid%0d", i), 32'(f_valid), 0);
      check($sformatf("t6.r_valid%0d", i), 32'(r_valid), 0);
      check($sformatf("t6.f_cnt%0d", i), 32'(f_cnt), 0);
      check($sformatf("t6.f_ovr%0d", i), 32'(f_ovr), 0);
      check($sformatf("t6.r_ovr%0d", i), 32'(r_ovr), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
